// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding, iteration count and the operand
// magnitude helper used when the operands are latched.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int         ITER_COUNT = 32;
    localparam logic [5:0] LAST_ITER  = 6'(ITER_COUNT - 1);

    // Absolute value for signed operations, raw value otherwise.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_addsub.sv
// fullAddSub32
// 32-bit adder/subtractor.
//   a, b    : operands
//   sub     : 0 -> sum = a + b, 1 -> sum = a - b (a + ~b + 1)
//   sum     : 32-bit result
//   carryO  : carry out of bit 31; when subtracting, 1 means no borrow (a >= b)
module fullAddSub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        carryO
);

    logic [32:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b ^ {32{sub}}} + {32'd0, sub};
    end

    assign sum    = full[31:0];
    assign carryO = full[32];

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative MIPS-style HI/LO multiply/divide unit. One bit per cycle over
// 32 iterations, with a PREP cycle (operand magnitudes and result signs)
// and a FIX cycle (sign correction, divide-by-zero override).
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   start, op     : request and operation (MULTU/MULT/DIVU/DIV)
//   rs, rt        : multiplicand/dividend, multiplier/divisor
//   wr_hi, wr_lo  : MTHI/MTLO strobes with wr_data
//   busy, done    : operation in progress / one-cycle completion pulse
//   hi, lo        : HI/LO registers
//   div_by_zero   : last divide had rt == 0 (valid from done to next start)
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // Control state (asynchronously reset)
    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dbz_q, dbz_d;

    // Datapath state (no reset needed; always loaded before use)
    op_e         op_q, op_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] mcand_q, mcand_d;   // multiplicand magnitude or divisor magnitude
    logic [31:0] acc_q, acc_d;       // product high half or partial remainder
    logic [31:0] shr_q, shr_d;       // multiplier bits / quotient bits
    logic        neg_q, neg_d;       // product / quotient must be negated
    logic        rem_neg_q, rem_neg_d;

    logic        accept;
    logic        is_div;
    logic        is_signed;
    logic        host_slot;

    // Shared adder
    logic [32:0] rem_sh;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_sub, add_carry;
    logic        div_ok;

    // Sign-corrected results
    logic signed [63:0] prod_fix;
    logic [31:0]        quo_fix, rem_fix;
    logic [31:0]        res_hi, res_lo;
    logic               res_dbz;

    assign host_slot = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept    = start && host_slot;
    assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_PREP;
            ST_PREP: state_d = ST_CALC;
            ST_CALC: if (cnt_q == LAST_ITER) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_PREP : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIX);
        done = (state_q == ST_DONE);
    end

    // ---------------- Iteration datapath ----------------
    // Restoring divide shifts the next dividend bit into the remainder; the
    // shifted remainder is 33 bits, and when its top bit is set it is always
    // >= divisor, so the 32-bit adder's carry alone decides the low case.
    assign rem_sh  = {acc_q, shr_q[31]};
    assign add_a   = is_div ? rem_sh[31:0] : acc_q;
    assign add_b   = is_div ? mcand_q : (shr_q[0] ? mcand_q : 32'd0);
    assign add_sub = is_div;
    assign div_ok  = rem_sh[32] | add_carry;

    fullAddSub32 u_addsub (
        .a      (add_a),
        .b      (add_b),
        .sub    (add_sub),
        .sum    (add_sum),
        .carryO (add_carry)
    );

    always_comb begin
        op_d      = op_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        shr_d     = shr_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        cnt_d     = cnt_q;

        if (accept) begin
            op_d = op_e'(op);
            rs_d = rs;
            rt_d = rt;
        end

        case (state_q)
            ST_PREP: begin
                mcand_d   = is_div ? magnitude(rt_q, is_signed) : magnitude(rs_q, is_signed);
                shr_d     = is_div ? magnitude(rs_q, is_signed) : magnitude(rt_q, is_signed);
                acc_d     = 32'd0;
                neg_d     = is_signed && (rs_q[31] ^ rt_q[31]);
                rem_neg_d = is_signed && rs_q[31];
                cnt_d     = 6'd0;
            end
            ST_CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (is_div) begin
                    acc_d = div_ok ? add_sum : rem_sh[31:0];
                    shr_d = {shr_q[30:0], div_ok};
                end else begin
                    // {carry, sum, multiplier} shifted right by one
                    acc_d = {add_carry, add_sum[31:1]};
                    shr_d = {add_sum[0], shr_q[31:1]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        op_q      <= op_d;
        rs_q      <= rs_d;
        rt_q      <= rt_d;
        mcand_q   <= mcand_d;
        acc_q     <= acc_d;
        shr_q     <= shr_d;
        neg_q     <= neg_d;
        rem_neg_q <= rem_neg_d;
    end

    // ---------------- Sign correction and HI/LO update ----------------
    always_comb begin
        prod_fix = neg_q ? -$signed({acc_q, shr_q}) : $signed({acc_q, shr_q});
        quo_fix  = neg_q ? -shr_q : shr_q;
        rem_fix  = rem_neg_q ? -acc_q : acc_q;
        res_dbz  = is_div && (rt_q == 32'd0);
        if (res_dbz) begin
            res_hi = rs_q;
            res_lo = 32'hFFFF_FFFF;
        end else if (is_div) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        dbz_d = dbz_q;
        if (host_slot) begin
            if (wr_hi) hi_d = wr_data;
            if (wr_lo) lo_d = wr_data;
        end
        if (accept) dbz_d = 1'b0;
        if (state_q == ST_FIX) begin
            hi_d  = res_hi;
            lo_d  = res_lo;
            dbz_d = res_dbz;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Directed bench for mult_div_unit with a transaction-level reference model
// checked every cycle, plus literal expectations on each operation.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one operation from plain arithmetic: {div_by_zero, hi, lo}.
    function automatic logic [64:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        case (o)
            2'd0: begin
                up = {32'd0, a} * {32'd0, b};
                return {1'b0, up};
            end
            2'd1: begin
                sp = sa * sb;
                return {1'b0, sp};
            end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
        endcase
    endfunction

    // Cycle model: an accepted request occupies the unit for 34 cycles,
    // then results appear together with a one-cycle done.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_dbz = 1'b0;
    logic [64:0] m_res = 65'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_dbz  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_dbz  <= m_res[64];
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end else begin
                if (wr_hi) m_hi <= wr_data;
                if (wr_lo) m_lo <= wr_data;
                if (start) begin
                    m_res  <= model_res(op, rs, rt);
                    m_left <= 34;
                    m_dbz  <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", {64'd0, busy}, {64'd0, m_left != 0});
            chk("cyc_done", {64'd0, done}, {64'd0, m_done});
            chk("cyc_hi", {33'd0, hi}, {33'd0, m_hi});
            chk("cyc_lo", {33'd0, lo}, {33'd0, m_lo});
            chk("cyc_dbz", {64'd0, div_by_zero}, {64'd0, m_dbz});
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    // Waits for done after an accepting edge; operands are scrambled while
    // busy. A second request plus an MTHI is injected at cycle 'poke' if > 0.
    task automatic wait_done(output int lat, input int poke);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                wr_hi = 1'b0;
                wr_lo = 1'b0;
            end
            rs = $urandom;
            rt = $urandom;
            if (poke > 0 && i == poke) begin
                start = 1'b1;
                op = 2'd2;
                rt = 32'd0;
                wr_hi = 1'b1;
                wr_data = 32'h1234;
            end
            if (poke > 0 && i == poke + 1) begin
                start = 1'b0;
                wr_hi = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic ed, input bit now);
        int lat;
        if (!now) @(negedge clk);
        op = o;
        rs = a;
        rt = b;
        start = 1'b1;
        wait_done(lat, 0);
        chk({name, "_latency"}, 65'(lat), 65'd35);
        chk({name, "_hi"}, {33'd0, hi}, {33'd0, eh});
        chk({name, "_lo"}, {33'd0, lo}, {33'd0, el});
        chk({name, "_dbz"}, {64'd0, div_by_zero}, {64'd0, ed});
    endtask

    initial begin
        int lat;
        int dc;

        #1 rst = 1'b1;
        #1;
        chk("rst_busy", {64'd0, busy}, 65'd0);
        chk("rst_done", {64'd0, done}, 65'd0);
        chk("rst_hi", {33'd0, hi}, 65'd0);
        chk("rst_lo", {33'd0, lo}, 65'd0);
        chk("rst_dbz", {64'd0, div_by_zero}, 65'd0);

        // Pin the reference model against hand-computed values.
        chk("model_multu", model_res(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 64'hFFFF_FFFE_0000_0001});
        chk("model_div", model_res(2'd3, 32'hFFFF_FFF9, 32'd2), {1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
        chk("model_divovf", model_res(2'd3, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 64'h0000_0000_8000_0000});

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // MTLO while idle
        @(negedge clk);
        wr_lo = 1'b1;
        wr_data = 32'hABCD;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("idle_mtlo", {33'd0, lo}, {33'd0, 32'hABCD});

        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mult_neg",  2'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
        run_op("mult_min",  2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op("div_neg",   2'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("div_negd",  2'd3, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("divu",      2'd2, 32'd100,      32'd7,         32'd2,         32'd14,        1'b0, 1'b0);
        run_op("divu_zero", 2'd2, 32'd100,      32'd0,         32'h64,        32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("div_ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0, 1'b0);
        run_op("div_zero",  2'd3, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
        // Restart straight from the done cycle
        run_op("b2b_divu",  2'd2, 32'hFFFF_FFFF, 32'd16,       32'd15,        32'h0FFF_FFFF, 1'b0, 1'b1);

        // Start and MTHI while busy are both ignored
        @(negedge clk);
        dc = done_cnt;
        op = 2'd0;
        rs = 32'h0001_0003;
        rt = 32'h0003_0000;
        start = 1'b1;
        wait_done(lat, 10);
        chk("ign_latency", 65'(lat), 65'd35);
        chk("ign_hi", {33'd0, hi}, {33'd0, 32'h0000_0003});
        chk("ign_lo", {33'd0, lo}, {33'd0, 32'h0009_0000});
        repeat (40) @(negedge clk);
        chk("ign_single_done", 65'(done_cnt - dc), 65'd1);

        // MTLO together with start: write lands, result overwrites later
        @(negedge clk);
        op = 2'd1;
        rs = 32'hFFFF_FFFA;
        rt = 32'd7;
        start = 1'b1;
        wr_lo = 1'b1;
        wr_data = 32'h5555;
        @(negedge clk);
        start = 1'b0;
        wr_lo = 1'b0;
        chk("mtlo_with_start", {33'd0, lo}, {33'd0, 32'h5555});
        wait_done(lat, 0);
        chk("mtlo_start_latency", 65'(lat), 65'd34);
        chk("mtlo_start_lo", {33'd0, lo}, {33'd0, 32'hFFFF_FFD6});
        chk("mtlo_start_hi", {33'd0, hi}, {33'd0, 32'hFFFF_FFFF});

        // Asynchronous reset mid-operation
        @(negedge clk);
        dc = done_cnt;
        op = 2'd2;
        rs = 32'd1000;
        rt = 32'd3;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {64'd0, busy}, 65'd0);
        chk("abort_hi", {33'd0, hi}, 65'd0);
        chk("abort_lo", {33'd0, lo}, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 65'(done_cnt - dc), 65'd0);

        run_op("post_rst", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
